result_collector: RTL and testbench

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector_pkg.sv | 14 +
 rtl/result_collector_slot_ram.sv | 26 ++
 rtl/result_collector.sv | 139 +++++++++++++
 tb/tb_result_collector.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_collector_pkg.sv
// Shared constants and FSM encoding for the result collector.
package result_collector_pkg;

  localparam int N_DEST_DEF = 64;
  localparam int DATA_W_DEF = 32;
  localparam int DEST_W     = 6;
  localparam int CNT_W      = 7;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_STREAM  = 1'b1
  } state_e;

endpackage

// File: rtl/result_collector_slot_ram.sv
// Result slot storage: one synchronous write port, one asynchronous read port.
module result_slot_ram #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Slot write; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/result_collector.sv
// Gathers dot-product results into slots, then streams them out in slot order
// once every slot has been filled at least once.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int N_DEST = N_DEST_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              DP_VALID,
  input  logic [DATA_W-1:0] DOT_PRODUCT,
  input  logic [DEST_W-1:0] DEST_O,
  input  logic              SOFT_CLR,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic              M_AXIS_TLAST,
  output logic              BUSY,
  output logic              DUP_ERR,
  output logic              OVERRUN
);

  localparam logic [DEST_W-1:0] LAST_IDX = DEST_W'(N_DEST - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_DEST - 1);

  state_e              r_state, w_state_nxt;
  logic [N_DEST-1:0]   r_fill, w_fill_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [DEST_W-1:0]   r_rd_idx, w_rd_idx_nxt;
  logic                r_dup_err, w_dup_err_nxt;
  logic                r_overrun, w_overrun_nxt;
  logic                w_wr_en;
  logic [DATA_W-1:0]   w_rd_data;

  result_slot_ram #(
    .DEPTH  (N_DEST),
    .DATA_W (DATA_W),
    .ADDR_W (DEST_W)
  ) u_slot_ram (
    .i_clk   (ACLK),
    .i_we    (w_wr_en),
    .i_waddr (DEST_O),
    .i_wdata (DOT_PRODUCT),
    .i_raddr (r_rd_idx),
    .o_rdata (w_rd_data)
  );

  // Next-state, bookkeeping and write-enable decode; SOFT_CLR wins over everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_fill_nxt    = r_fill;
    w_cnt_nxt     = r_cnt;
    w_rd_idx_nxt  = r_rd_idx;
    w_dup_err_nxt = r_dup_err;
    w_overrun_nxt = r_overrun;
    w_wr_en       = 1'b0;
    if (SOFT_CLR) begin
      w_state_nxt   = ST_COLLECT;
      w_fill_nxt    = {N_DEST{1'b0}};
      w_cnt_nxt     = {CNT_W{1'b0}};
      w_rd_idx_nxt  = {DEST_W{1'b0}};
      w_dup_err_nxt = 1'b0;
      w_overrun_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (DP_VALID) begin
            w_wr_en = 1'b1;
            if (r_fill[DEST_O]) begin
              w_dup_err_nxt = 1'b1;
            end else begin
              w_fill_nxt[DEST_O] = 1'b1;
              w_cnt_nxt          = r_cnt + CNT_W'(1);
              if (r_cnt == LAST_CNT) begin
                w_state_nxt  = ST_STREAM;
                w_rd_idx_nxt = {DEST_W{1'b0}};
              end else begin
                w_state_nxt  = ST_COLLECT;
              end
            end
          end else begin
            w_wr_en = 1'b0;
          end
        end
        ST_STREAM: begin
          // Results arriving now have nowhere to go, including on the final beat.
          if (DP_VALID) begin
            w_overrun_nxt = 1'b1;
          end else begin
            w_overrun_nxt = r_overrun;
          end
          if (M_AXIS_TREADY) begin
            if (r_rd_idx == LAST_IDX) begin
              w_state_nxt  = ST_COLLECT;
              w_fill_nxt   = {N_DEST{1'b0}};
              w_cnt_nxt    = {CNT_W{1'b0}};
              w_rd_idx_nxt = {DEST_W{1'b0}};
            end else begin
              w_rd_idx_nxt = r_rd_idx + DEST_W'(1);
            end
          end else begin
            w_rd_idx_nxt = r_rd_idx;
          end
        end
        default: begin
          w_state_nxt = ST_COLLECT;
        end
      endcase
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state   <= ST_COLLECT;
      r_fill    <= {N_DEST{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_rd_idx  <= {DEST_W{1'b0}};
      r_dup_err <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_fill    <= w_fill_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rd_idx  <= w_rd_idx_nxt;
      r_dup_err <= w_dup_err_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign BUSY          = (r_state == ST_STREAM);
  assign M_AXIS_TVALID = (r_state == ST_STREAM);
  assign M_AXIS_TLAST  = (r_state == ST_STREAM) && (r_rd_idx == LAST_IDX);
  assign M_AXIS_TDATA  = (r_state == ST_STREAM) ? w_rd_data : {DATA_W{1'b0}};
  assign DUP_ERR       = r_dup_err;
  assign OVERRUN       = r_overrun;

endmodule

// File: tb/tb_result_collector.sv
// Randomized bench for result_collector with a slot-array reference model.
module tb_result_collector;

  localparam int N = 64;
  localparam int W = 32;

  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic         DP_VALID;
  logic [W-1:0] DOT_PRODUCT;
  logic [5:0]   DEST_O;
  logic         SOFT_CLR;
  logic [W-1:0] M_AXIS_TDATA;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TREADY;
  logic         M_AXIS_TLAST;
  logic         BUSY;
  logic         DUP_ERR;
  logic         OVERRUN;

  result_collector #(.N_DEST(N), .DATA_W(W)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .DP_VALID      (DP_VALID),
    .DOT_PRODUCT   (DOT_PRODUCT),
    .DEST_O        (DEST_O),
    .SOFT_CLR      (SOFT_CLR),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .BUSY          (BUSY),
    .DUP_ERR       (DUP_ERR),
    .OVERRUN       (OVERRUN)
  );

  always #5 ACLK = ~ACLK;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: slot contents, which slots hold a result, flags, stream position.
  logic [W-1:0] m_mem [N];
  bit           m_fill [N];
  bit           m_dup;
  bit           m_ovr;
  bit           m_stream;
  int           m_idx;

  function automatic int m_count();
    int c = 0;
    foreach (m_fill[i]) if (m_fill[i]) c++;
    return c;
  endfunction

  task automatic m_new_collection();
    foreach (m_fill[i]) m_fill[i] = 1'b0;
    m_stream = 1'b0;
    m_idx    = 0;
  endtask

  task automatic write_slot(input int d, input logic [W-1:0] v);
    DP_VALID    = 1'b1;
    DEST_O      = 6'(d);
    DOT_PRODUCT = v;
    @(negedge ACLK);
    DP_VALID = 1'b0;
    if (m_stream) begin
      m_ovr = 1'b1;
    end else begin
      if (m_fill[d]) m_dup = 1'b1;
      m_fill[d] = 1'b1;
      m_mem[d]  = v;
      if (m_count() == N) begin
        m_stream = 1'b1;
        m_idx    = 0;
      end
    end
    n_total++;
    if (BUSY !== m_stream || M_AXIS_TVALID !== m_stream)
      $display("FAIL write_busy slot=%0d: busy=%b tvalid=%b, expected %b", d, BUSY, M_AXIS_TVALID, m_stream);
    else n_pass++;
    n_total++;
    if (DUP_ERR !== m_dup || OVERRUN !== m_ovr)
      $display("FAIL write_flags slot=%0d: dup=%b ovr=%b, expected dup=%b ovr=%b", d, DUP_ERR, OVERRUN, m_dup, m_ovr);
    else n_pass++;
  endtask

  // order: 0 ascending, 1 descending, 2 shuffled; data x3 or random.
  task automatic collect(input int order, input bit data_x3);
    int perm [N];
    for (int i = 0; i < N; i++) perm[i] = (order == 1) ? (N - 1 - i) : i;
    if (order == 2) begin
      for (int i = N - 1; i > 0; i--) begin
        int j;
        int t;
        j = int'($urandom_range(i, 0));
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
    end
    for (int i = 0; i < N; i++)
      write_slot(perm[i], data_x3 ? W'(perm[i] * 3) : W'($urandom()));
  endtask

  // mode: 0 ready always, 1 ready toggling, 2 ready random. stop_beat < 0 runs to the end.
  task automatic run_stream(input int mode, input bit dp_rand, input bit dp_on_last, input int stop_beat);
    int           cyc = 0;
    logic [W-1:0] prev = '0;
    bit           stalled = 1'b0;
    bit           r;
    bit           dp;
    while (m_stream && cyc < 1000) begin
      if (stop_beat >= 0 && m_idx == stop_beat) break;
      n_total++;
      if (M_AXIS_TVALID !== 1'b1 || BUSY !== 1'b1)
        $display("FAIL stream_valid beat=%0d: tvalid=%b busy=%b, expected 1", m_idx, M_AXIS_TVALID, BUSY);
      else n_pass++;
      n_total++;
      if (M_AXIS_TDATA !== m_mem[m_idx])
        $display("FAIL stream_data beat=%0d: got %h, expected %h", m_idx, M_AXIS_TDATA, m_mem[m_idx]);
      else n_pass++;
      n_total++;
      if (M_AXIS_TLAST !== 1'(m_idx == N - 1))
        $display("FAIL stream_last beat=%0d: got %b", m_idx, M_AXIS_TLAST);
      else n_pass++;
      if (stalled) begin
        n_total++;
        if (M_AXIS_TDATA !== prev)
          $display("FAIL stall_stable beat=%0d: got %h, held value %h", m_idx, M_AXIS_TDATA, prev);
        else n_pass++;
      end
      n_total++;
      if (OVERRUN !== m_ovr || DUP_ERR !== m_dup)
        $display("FAIL stream_flags beat=%0d: ovr=%b dup=%b, expected ovr=%b dup=%b", m_idx, OVERRUN, DUP_ERR, m_ovr, m_dup);
      else n_pass++;
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = ((cyc % 2) == 0);
      else r = 1'($urandom_range(1, 0));
      M_AXIS_TREADY = r;
      dp = dp_rand ? ($urandom_range(3, 0) == 0) : 1'b0;
      if (dp_on_last && r && m_idx == N - 1) dp = 1'b1;
      if (dp) begin
        DP_VALID    = 1'b1;
        DEST_O      = 6'($urandom_range(N - 1, 0));
        DOT_PRODUCT = $urandom();
      end
      prev = M_AXIS_TDATA;
      @(negedge ACLK);
      cyc++;
      DP_VALID = 1'b0;
      if (dp) m_ovr = 1'b1;
      if (r) begin
        if (m_idx == N - 1) m_new_collection();
        else m_idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
    end
    M_AXIS_TREADY = 1'b0;
    if (cyc >= 1000) begin
      n_total++;
      $display("FAIL stream_timeout: stream still active after %0d cycles", cyc);
    end
    if (!m_stream) begin
      n_total++;
      if (M_AXIS_TVALID !== 1'b0 || BUSY !== 1'b0 || M_AXIS_TLAST !== 1'b0)
        $display("FAIL stream_end: tvalid=%b busy=%b tlast=%b, expected 0", M_AXIS_TVALID, BUSY, M_AXIS_TLAST);
      else n_pass++;
    end
  endtask

  task automatic do_soft_clr(input bit with_dp);
    SOFT_CLR    = 1'b1;
    DP_VALID    = with_dp;
    DEST_O      = 6'($urandom_range(N - 1, 0));
    DOT_PRODUCT = $urandom();
    @(negedge ACLK);
    SOFT_CLR = 1'b0;
    DP_VALID = 1'b0;
    m_new_collection();
    m_dup = 1'b0;
    m_ovr = 1'b0;
    n_total++;
    if (DUP_ERR !== 1'b0 || OVERRUN !== 1'b0 || BUSY !== 1'b0)
      $display("FAIL soft_clr: dup=%b ovr=%b busy=%b, expected 0", DUP_ERR, OVERRUN, BUSY);
    else n_pass++;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; DP_VALID = 1'b0; DOT_PRODUCT = '0; DEST_O = '0;
    SOFT_CLR = 1'b0; M_AXIS_TREADY = 1'b0;
    m_new_collection(); m_dup = 1'b0; m_ovr = 1'b0;
    #2;
    n_total++;
    if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0 || BUSY !== 1'b0 ||
        DUP_ERR !== 1'b0 || OVERRUN !== 1'b0 || M_AXIS_TDATA !== 32'h0)
      $display("FAIL reset: tvalid=%b tlast=%b busy=%b dup=%b ovr=%b tdata=%h, expected all 0",
               M_AXIS_TVALID, M_AXIS_TLAST, BUSY, DUP_ERR, OVERRUN, M_AXIS_TDATA);
    else n_pass++;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  task automatic test_in_order();
    collect(0, 1'b1);
    run_stream(0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_permuted_stall();
    collect(1, 1'b0);
    run_stream(1, 1'b0, 1'b0, -1);
    collect(2, 1'b0);
    run_stream(2, 1'b0, 1'b0, -1);
  endtask

  task automatic test_dup();
    write_slot(5, 32'h11);
    write_slot(5, 32'h22);
    for (int d = 0; d < N; d++) if (d != 5) write_slot(d, $urandom());
    n_total++;
    if (DUP_ERR !== 1'b1) $display("FAIL dup_flag: got %b, expected 1", DUP_ERR);
    else n_pass++;
    run_stream(0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_overrun();
    do_soft_clr(1'b0);
    collect(2, 1'b0);
    run_stream(2, 1'b1, 1'b1, -1);
    n_total++;
    if (OVERRUN !== 1'b1) $display("FAIL overrun_flag: got %b, expected 1", OVERRUN);
    else n_pass++;
    collect(2, 1'b0);
    run_stream(0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_async_reset();
    collect(2, 1'b0);
    run_stream(0, 1'b0, 1'b0, 20);
    M_AXIS_TREADY = 1'b1;
    #2 ARESETN = 1'b0;
    #1;
    m_new_collection(); m_dup = 1'b0; m_ovr = 1'b0;
    n_total++;
    if (M_AXIS_TVALID !== 1'b0 || BUSY !== 1'b0 || M_AXIS_TDATA !== 32'h0 || OVERRUN !== 1'b0)
      $display("FAIL async_reset: tvalid=%b busy=%b tdata=%h ovr=%b, expected 0", M_AXIS_TVALID, BUSY, M_AXIS_TDATA, OVERRUN);
    else n_pass++;
    @(negedge ACLK);
    n_total++;
    if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0)
      $display("FAIL reset_hold: tvalid=%b tlast=%b, expected 0", M_AXIS_TVALID, M_AXIS_TLAST);
    else n_pass++;
    ARESETN = 1'b1;
    M_AXIS_TREADY = 1'b0;
    collect(2, 1'b0);
    run_stream(1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_soft_clr();
    int perm [N];
    collect(0, 1'b0);
    run_stream(0, 1'b0, 1'b1, -1);
    for (int i = 0; i < N; i++) perm[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 40; i++) write_slot(perm[i], $urandom());
    write_slot(perm[0], $urandom());
    n_total++;
    if (DUP_ERR !== 1'b1 || OVERRUN !== 1'b1)
      $display("FAIL pre_clr_flags: dup=%b ovr=%b, expected 1", DUP_ERR, OVERRUN);
    else n_pass++;
    do_soft_clr(1'b1);
    collect(2, 1'b0);
    run_stream(2, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_permuted_stall();
    test_dup();
    test_overrun();
    test_async_reset();
    test_soft_clr();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
